// File: rtl/udp_parser.sv
// UDP header parser: strips the 8-byte header, filters on destination port, forwards the payload.
// Optional packet/error counters are enabled with the UDP_PARSER_STATS_EN macro.
module udp_parser #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter logic [15:0] TARGET_PORT = 16'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [63:0]           s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [96:0]           m_axis_tuser,
  input  logic                  m_axis_tready
`ifdef UDP_PARSER_STATS_EN
  ,
  output logic [31:0]           stat_fwd_pkts,
  output logic [31:0]           stat_drop_pkts,
  output logic [15:0]           stat_len_err
`endif
);

  typedef enum logic [1:0] {StHeader, StPayload, StDrain, StDrop} state_e;

  state_e      state_q, state_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] src_port_q, src_port_d;
  logic [15:0] dst_port_q, dst_port_d;
  logic [15:0] length_q, length_d;
  logic [63:0] ip_q, ip_d;
  logic        beat;
  logic        len_err;

  assign s_axis_tready = (state_q == StPayload) ? m_axis_tready : 1'b1;
  assign beat          = s_axis_tvalid && s_axis_tready;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tuser  = {len_err, ip_q, src_port_q, dst_port_q};

  always_comb begin
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    remaining_d   = remaining_q;
    src_port_d    = src_port_q;
    dst_port_d    = dst_port_q;
    length_d      = length_q;
    ip_d          = ip_q;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    len_err       = 1'b0;

    unique case (state_q)
      StHeader: begin
        if (beat) begin
          unique case (hdr_cnt_q)
            3'd0: begin
              ip_d             = s_axis_tuser;
              src_port_d[15:8] = s_axis_tdata;
            end
            3'd1:    src_port_d[7:0] = s_axis_tdata;
            3'd2:    dst_port_d[15:8] = s_axis_tdata;
            3'd3:    dst_port_d[7:0]  = s_axis_tdata;
            3'd4:    length_d[15:8]   = s_axis_tdata;
            3'd5:    length_d[7:0]    = s_axis_tdata;
            default: ;
          endcase
          if (s_axis_tlast) begin
            // Runt: too short to carry a full header, discard silently.
            hdr_cnt_d = 3'd0;
          end else if (hdr_cnt_q == 3'd7) begin
            hdr_cnt_d = 3'd0;
            if (length_q <= 16'd8 || (TARGET_PORT != 16'd0 && dst_port_q != TARGET_PORT)) begin
              state_d = StDrop;
            end else begin
              state_d     = StPayload;
              remaining_d = length_q - 16'd8;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
          end
        end
      end
      StPayload: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast || (remaining_q == 16'd1);
        len_err       = s_axis_tvalid && s_axis_tlast && (remaining_q != 16'd1);
        if (beat) begin
          remaining_d = remaining_q - 16'd1;
          if (s_axis_tlast) begin
            state_d = StHeader;
          end else if (remaining_q == 16'd1) begin
            state_d = StDrain;
          end
        end
      end
      StDrain, StDrop: begin
        if (beat && s_axis_tlast) state_d = StHeader;
      end
      default: state_d = StHeader;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHeader;
      hdr_cnt_q   <= 3'd0;
      remaining_q <= 16'd0;
      src_port_q  <= 16'd0;
      dst_port_q  <= 16'd0;
      length_q    <= 16'd0;
      ip_q        <= 64'd0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      remaining_q <= remaining_d;
      src_port_q  <= src_port_d;
      dst_port_q  <= dst_port_d;
      length_q    <= length_d;
      ip_q        <= ip_d;
    end
  end

`ifdef UDP_PARSER_STATS_EN
  logic runt;
  logic drop_entry;

  assign runt       = (state_q == StHeader) && beat && s_axis_tlast;
  assign drop_entry = (state_q == StHeader) && (state_d == StDrop);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fwd_pkts  <= 32'd0;
      stat_drop_pkts <= 32'd0;
      stat_len_err   <= 16'd0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) stat_fwd_pkts <= stat_fwd_pkts + 32'd1;
      if (runt || drop_entry) stat_drop_pkts <= stat_drop_pkts + 32'd1;
      if (beat && len_err) stat_len_err <= stat_len_err + 16'd1;
    end
  end
`endif

endmodule
